ext_mem_arbiter: RTL and testbench

- Shares the single external cache-line memory port between the I-cache refill requester and the D-cache refill/write-back requester.
- Sits between the I/D cache master interfaces and the M_IMEM/M_DMEM-facing memory controller, which gives a one-port memory subsystem.
- Arbitrates round-robin on ties and registers every memory-side output.
- Keeps saturating per-requester grant counters for profiling.

---
 rtl/ext_mem_arbiter_if.sv | 42 ++++
 rtl/ext_mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_ext_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ext_mem_arbiter_if.sv
// Bus bundle between the I/D cache requesters, the arbiter and the memory port.
//   slave  : arbiter view. It takes the requests and m_done/m_data, and drives
//            the done/data returns and the m_* request.
//   master : environment view. It drives the requests and the memory
//            response, and observes the arbiter outputs.
interface ext_mem_arbiter_if #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned CLSIZE = 128
);
   logic              i_strobe_i;
   logic [XLEN-1:0]   i_addr_i;
   logic              i_done_o;
   logic [CLSIZE-1:0] i_data_o;

   logic              d_strobe_i;
   logic [XLEN-1:0]   d_addr_i;
   logic              d_rw_i;
   logic [CLSIZE-1:0] d_data_i;
   logic              d_done_o;
   logic [CLSIZE-1:0] d_data_o;

   logic              m_strobe_o;
   logic [XLEN-1:0]   m_addr_o;
   logic              m_rw_o;
   logic [CLSIZE-1:0] m_data_o;
   logic              m_done_i;
   logic [CLSIZE-1:0] m_data_i;

   modport slave (
      input  i_strobe_i, i_addr_i, d_strobe_i, d_addr_i, d_rw_i, d_data_i,
             m_done_i, m_data_i,
      output i_done_o, i_data_o, d_done_o, d_data_o,
             m_strobe_o, m_addr_o, m_rw_o, m_data_o
   );

   modport master (
      output i_strobe_i, i_addr_i, d_strobe_i, d_addr_i, d_rw_i, d_data_i,
             m_done_i, m_data_i,
      input  i_done_o, i_data_o, d_done_o, d_data_o,
             m_strobe_o, m_addr_o, m_rw_o, m_data_o
   );
endinterface

// File: rtl/ext_mem_arbiter.sv
// Shares one external cache-line memory port between the I-cache refill
// requester and the D-cache refill/write-back requester. Ties are broken
// round-robin. All outputs are registered.
//   clk_i, rst_i   : clock and asynchronous active-low reset
//   bus (slave)    : I/D request/return handshakes and the memory port
//   busy_o         : high whenever a transaction is in flight or releasing
//   i/d_grant_cnt_o: saturating grant counters for profiling
module ext_mem_arbiter #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned CLSIZE = 128,
   parameter int unsigned CNT_W  = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   ext_mem_arbiter_if.slave     bus,
   output logic                 busy_o,
   output logic [CNT_W-1:0]     i_grant_cnt_o,
   output logic [CNT_W-1:0]     d_grant_cnt_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RELEASE} state_e;
   typedef enum logic {OWN_I, OWN_D} owner_e;

   state_e            state_q,    state_d;
   owner_e            owner_q,    owner_d;
   owner_e            last_q,     last_d;
   logic              m_strobe_q, m_strobe_d;
   logic [XLEN-1:0]   m_addr_q,   m_addr_d;
   logic              m_rw_q,     m_rw_d;
   logic [CLSIZE-1:0] m_data_q,   m_data_d;
   logic              i_done_q,   i_done_d;
   logic              d_done_q,   d_done_d;
   logic [CLSIZE-1:0] i_data_q,   i_data_d;
   logic [CLSIZE-1:0] d_data_q,   d_data_d;
   logic              busy_q,     busy_d;
   logic [CNT_W-1:0]  i_cnt_q,    i_cnt_d;
   logic [CNT_W-1:0]  d_cnt_q,    d_cnt_d;
   logic              pick_d_c;

   // D wins when it is the only requester, or on a tie when I was granted last.
   assign pick_d_c = bus.d_strobe_i & (~bus.i_strobe_i | (last_q == OWN_I));

   // Next-state and output logic.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_d     = last_q;
      m_strobe_d = m_strobe_q;
      m_addr_d   = m_addr_q;
      m_rw_d     = m_rw_q;
      m_data_d   = m_data_q;
      i_done_d   = 1'b0;
      d_done_d   = 1'b0;
      i_data_d   = i_data_q;
      d_data_d   = d_data_q;
      busy_d     = busy_q;
      i_cnt_d    = i_cnt_q;
      d_cnt_d    = d_cnt_q;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.i_strobe_i || bus.d_strobe_i) begin
               state_d    = ST_BUSY;
               busy_d     = 1'b1;
               m_strobe_d = 1'b1;
               if (pick_d_c) begin
                  owner_d  = OWN_D;
                  last_d   = OWN_D;
                  m_addr_d = bus.d_addr_i;
                  m_rw_d   = bus.d_rw_i;
                  m_data_d = bus.d_data_i;
                  if (~&d_cnt_q) d_cnt_d = d_cnt_q + CNT_W'(1);
               end else begin
                  owner_d  = OWN_I;
                  last_d   = OWN_I;
                  m_addr_d = bus.i_addr_i;
                  m_rw_d   = 1'b0;
                  m_data_d = '0;
                  if (~&i_cnt_q) i_cnt_d = i_cnt_q + CNT_W'(1);
               end
            end
         end
         ST_BUSY: begin
            if (bus.m_done_i) begin
               state_d    = ST_RELEASE;
               m_strobe_d = 1'b0;
               if (owner_q == OWN_D) begin
                  d_done_d = 1'b1;
                  d_data_d = bus.m_data_i;
               end else begin
                  i_done_d = 1'b1;
                  i_data_d = bus.m_data_i;
               end
            end
         end
         ST_RELEASE: begin
            // Dead cycle so a strobe still high from the finished requester
            // is not re-granted.
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= ST_IDLE;
         owner_q    <= OWN_I;
         last_q     <= OWN_I;
         m_strobe_q <= 1'b0;
         m_addr_q   <= '0;
         m_rw_q     <= 1'b0;
         m_data_q   <= '0;
         i_done_q   <= 1'b0;
         d_done_q   <= 1'b0;
         i_data_q   <= '0;
         d_data_q   <= '0;
         busy_q     <= 1'b0;
         i_cnt_q    <= '0;
         d_cnt_q    <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         m_strobe_q <= m_strobe_d;
         m_addr_q   <= m_addr_d;
         m_rw_q     <= m_rw_d;
         m_data_q   <= m_data_d;
         i_done_q   <= i_done_d;
         d_done_q   <= d_done_d;
         i_data_q   <= i_data_d;
         d_data_q   <= d_data_d;
         busy_q     <= busy_d;
         i_cnt_q    <= i_cnt_d;
         d_cnt_q    <= d_cnt_d;
      end
   end

   assign bus.m_strobe_o = m_strobe_q;
   assign bus.m_addr_o   = m_addr_q;
   assign bus.m_rw_o     = m_rw_q;
   assign bus.m_data_o   = m_data_q;
   assign bus.i_done_o   = i_done_q;
   assign bus.i_data_o   = i_data_q;
   assign bus.d_done_o   = d_done_q;
   assign bus.d_data_o   = d_data_q;
   assign busy_o         = busy_q;
   assign i_grant_cnt_o  = i_cnt_q;
   assign d_grant_cnt_o  = d_cnt_q;

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Directed bench for ext_mem_arbiter: single read, tie-break, write,
// alternation, spurious done and ignored address change, mid-transaction reset.
module tb_ext_mem_arbiter;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned CLSIZE = 128;
   localparam int unsigned CNT_W  = 32;

   localparam logic [XLEN-1:0] I_ADDR0 = 32'h8000_0000;
   localparam logic [XLEN-1:0] I_ADDR1 = 32'h8000_0040;
   localparam logic [XLEN-1:0] D_ADDR0 = 32'h8000_1000;
   localparam logic [XLEN-1:0] D_ADDR2 = 32'h8000_2000;
   localparam logic [XLEN-1:0] D_ADDR3 = 32'h8000_3000;

   logic             clk;
   logic             rst_n;
   logic             busy;
   logic [CNT_W-1:0] i_cnt;
   logic [CNT_W-1:0] d_cnt;

   int n_chk;
   int n_pass;
   int hi;

   logic [CLSIZE-1:0] pat_a5;
   logic [CLSIZE-1:0] pat_wr;

   ext_mem_arbiter_if #(.XLEN(XLEN), .CLSIZE(CLSIZE)) bus ();

   ext_mem_arbiter #(.XLEN(XLEN), .CLSIZE(CLSIZE), .CNT_W(CNT_W)) dut (
      .clk_i         (clk),
      .rst_i         (rst_n),
      .bus           (bus),
      .busy_o        (busy),
      .i_grant_cnt_o (i_cnt),
      .d_grant_cnt_o (d_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic clear_inputs();
      bus.i_strobe_i = 1'b0;
      bus.i_addr_i   = '0;
      bus.d_strobe_i = 1'b0;
      bus.d_addr_i   = '0;
      bus.d_rw_i     = 1'b0;
      bus.d_data_i   = '0;
      bus.m_done_i   = 1'b0;
      bus.m_data_i   = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   // Memory model: called just after the grant edge. Counts cycles with
   // m_strobe_o high and returns m_done_i so it is sampled at the lat-th edge.
   task automatic serve(input int lat, input logic [CLSIZE-1:0] data, output int hi_cyc);
      hi_cyc = 0;
      for (int c = 0; c < lat; c++) begin
         if (bus.m_strobe_o) hi_cyc++;
         if (c == lat - 1) begin
            bus.m_done_i = 1'b1;
            bus.m_data_i = data;
         end
         step();
      end
      bus.m_done_i = 1'b0;
      bus.m_data_i = '0;
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      pat_a5 = {16{8'hA5}};
      pat_wr = {8{16'h1234}};
      clear_inputs();
      rst_n = 1'b0;
      #3;
      chk("rst_m_strobe", 128'(bus.m_strobe_o), 128'(0));
      chk("rst_busy",     128'(busy),           128'(0));
      chk("rst_i_cnt",    128'(i_cnt),          128'(0));
      chk("rst_d_cnt",    128'(d_cnt),          128'(0));
      chk("rst_i_data",   bus.i_data_o,         128'(0));
      chk("rst_d_data",   bus.d_data_o,         128'(0));
      step();
      rst_n = 1'b1;

      // 1. Single I read, 5-cycle memory.
      bus.i_strobe_i = 1'b1;
      bus.i_addr_i   = I_ADDR1;
      step();
      chk("t1_m_strobe", 128'(bus.m_strobe_o), 128'(1));
      chk("t1_m_addr",   128'(bus.m_addr_o),   128'(I_ADDR1));
      chk("t1_m_rw",     128'(bus.m_rw_o),     128'(0));
      chk("t1_busy",     128'(busy),           128'(1));
      chk("t1_i_cnt",    128'(i_cnt),          128'(1));
      serve(5, pat_a5, hi);
      chk("t1_strobe_cycles", 128'(hi),             128'(5));
      chk("t1_i_done",        128'(bus.i_done_o),   128'(1));
      chk("t1_i_data",        bus.i_data_o,         pat_a5);
      chk("t1_d_done",        128'(bus.d_done_o),   128'(0));
      chk("t1_m_strobe_off",  128'(bus.m_strobe_o), 128'(0));
      bus.i_strobe_i = 1'b0;
      step();
      chk("t1_i_done_pulse",  128'(bus.i_done_o),   128'(0));
      chk("t1_idle",          128'(busy),           128'(0));

      // 2. Tie after reset: D first, then I.
      do_reset();
      bus.i_strobe_i = 1'b1;
      bus.i_addr_i   = I_ADDR0;
      bus.d_strobe_i = 1'b1;
      bus.d_addr_i   = D_ADDR0;
      step();
      chk("t2_first_addr", 128'(bus.m_addr_o), 128'(D_ADDR0));
      chk("t2_d_cnt1",     128'(d_cnt),        128'(1));
      chk("t2_i_cnt0",     128'(i_cnt),        128'(0));
      serve(2, {4{32'hBBBB_0001}}, hi);
      chk("t2_d_done", 128'(bus.d_done_o), 128'(1));
      chk("t2_i_done", 128'(bus.i_done_o), 128'(0));
      chk("t2_d_data", bus.d_data_o,       {4{32'hBBBB_0001}});
      bus.d_strobe_i = 1'b0;
      step();
      chk("t2_release_no_grant", 128'(bus.m_strobe_o), 128'(0));
      step();
      chk("t2_second_addr", 128'(bus.m_addr_o),   128'(I_ADDR0));
      chk("t2_second_strb", 128'(bus.m_strobe_o), 128'(1));
      serve(1, {4{32'hCCCC_0002}}, hi);
      chk("t2_i_done2", 128'(bus.i_done_o), 128'(1));
      chk("t2_i_data",  bus.i_data_o,       {4{32'hCCCC_0002}});
      chk("t2_d_data_held", bus.d_data_o,   {4{32'hBBBB_0001}});
      bus.i_strobe_i = 1'b0;
      step();
      chk("t2_i_cnt", 128'(i_cnt), 128'(1));
      chk("t2_d_cnt", 128'(d_cnt), 128'(1));

      // 3. D write; m_data_o stable despite d_data_i change.
      bus.d_strobe_i = 1'b1;
      bus.d_addr_i   = D_ADDR2;
      bus.d_rw_i     = 1'b1;
      bus.d_data_i   = pat_wr;
      step();
      chk("t3_m_rw",   128'(bus.m_rw_o),   128'(1));
      chk("t3_m_addr", 128'(bus.m_addr_o), 128'(D_ADDR2));
      chk("t3_m_data", bus.m_data_o,       pat_wr);
      bus.d_data_i = '1;
      bus.d_rw_i   = 1'b0;
      step();
      chk("t3_m_data_stable", bus.m_data_o,     pat_wr);
      chk("t3_m_rw_stable",   128'(bus.m_rw_o), 128'(1));
      serve(2, {4{32'hEEEE_0003}}, hi);
      chk("t3_d_done", 128'(bus.d_done_o), 128'(1));
      chk("t3_i_done", 128'(bus.i_done_o), 128'(0));
      chk("t3_d_data", bus.d_data_o,       {4{32'hEEEE_0003}});
      bus.d_strobe_i = 1'b0;
      step();

      // 4. Continuous requests from both: D, I, D, I, D, I.
      do_reset();
      bus.i_strobe_i = 1'b1;
      bus.i_addr_i   = I_ADDR0;
      bus.d_strobe_i = 1'b1;
      bus.d_addr_i   = D_ADDR0;
      for (int k = 0; k < 6; k++) begin
         step();
         chk($sformatf("t4_grant%0d_addr", k), 128'(bus.m_addr_o),
             128'(((k % 2) == 0) ? D_ADDR0 : I_ADDR0));
         chk($sformatf("t4_grant%0d_busy", k), 128'(busy), 128'(1));
         serve(2, 128'(k + 16), hi);
         chk($sformatf("t4_done%0d_d", k), 128'(bus.d_done_o), 128'(((k % 2) == 0) ? 1 : 0));
         chk($sformatf("t4_done%0d_i", k), 128'(bus.i_done_o), 128'(((k % 2) == 0) ? 0 : 1));
         step();
         chk($sformatf("t4_idle%0d", k), 128'(busy), 128'(0));
      end
      bus.i_strobe_i = 1'b0;
      bus.d_strobe_i = 1'b0;
      chk("t4_i_cnt", 128'(i_cnt), 128'(3));
      chk("t4_d_cnt", 128'(d_cnt), 128'(3));
      step();

      // 5. Spurious m_done_i in IDLE; d_addr_i change during BUSY.
      bus.m_done_i = 1'b1;
      bus.m_data_i = '1;
      step();
      bus.m_done_i = 1'b0;
      chk("t5_spur_i_done", 128'(bus.i_done_o), 128'(0));
      chk("t5_spur_d_done", 128'(bus.d_done_o), 128'(0));
      chk("t5_spur_busy",   128'(busy),         128'(0));
      bus.d_strobe_i = 1'b1;
      bus.d_addr_i   = D_ADDR3;
      bus.d_rw_i     = 1'b0;
      step();
      bus.d_addr_i = 32'hDEAD_0000;
      step();
      chk("t5_addr_held", 128'(bus.m_addr_o), 128'(D_ADDR3));
      serve(2, {4{32'hF0F0_0005}}, hi);
      chk("t5_d_done", 128'(bus.d_done_o), 128'(1));
      chk("t5_d_data", bus.d_data_o,       {4{32'hF0F0_0005}});
      bus.d_strobe_i = 1'b0;
      step();

      // 6. Reset during BUSY, then a late m_done_i.
      bus.i_strobe_i = 1'b1;
      bus.i_addr_i   = I_ADDR1;
      step();
      step();
      chk("t6_busy_before", 128'(busy), 128'(1));
      rst_n = 1'b0;
      bus.i_strobe_i = 1'b0;
      #1;
      chk("t6_rst_m_strobe", 128'(bus.m_strobe_o), 128'(0));
      chk("t6_rst_m_addr",   128'(bus.m_addr_o),   128'(0));
      chk("t6_rst_busy",     128'(busy),           128'(0));
      chk("t6_rst_i_cnt",    128'(i_cnt),          128'(0));
      chk("t6_rst_d_cnt",    128'(d_cnt),          128'(0));
      chk("t6_rst_d_data",   bus.d_data_o,         128'(0));
      step();
      rst_n = 1'b1;
      bus.m_done_i = 1'b1;
      bus.m_data_i = pat_a5;
      step();
      bus.m_done_i = 1'b0;
      step();
      chk("t6_late_i_done", 128'(bus.i_done_o),   128'(0));
      chk("t6_late_d_done", 128'(bus.d_done_o),   128'(0));
      chk("t6_late_busy",   128'(busy),           128'(0));
      chk("t6_late_strobe", 128'(bus.m_strobe_o), 128'(0));
      chk("t6_late_i_data", bus.i_data_o,         128'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
